// File: rtl/id_stage_fwd.sv
// id_stage_fwd: MIPS-subset decode stage with a registered ID/EX output.
// Handshake is valid/ready on both sides. Operands are resolved against
// FWD_N younger pipeline stages, and a load-use hazard inserts one bubble.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready, pc_i, inst_i           - instruction from IF/ID
//   rf_re*/rf_ra*/rf_rd*                      - register-file read port
//   fwd_wreg_i/fwd_wd_i/fwd_wdata_i           - forwarding sources, index 0 youngest
//   out_valid/out_ready, pc_o..is_load_o      - ID/EX register towards execute
//   inst_err_o, stall_cnt_o                   - undecodable flag, saturating load-use stall count
// Latency: an accepted instruction appears on the outputs after one edge.
// Backpressure: outputs hold while out_valid & ~out_ready.
module id_stage_fwd #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              inst_i,
  output logic                     rf_re1_o,
  output logic                     rf_re2_o,
  output logic [REG_AW-1:0]        rf_ra1_o,
  output logic [REG_AW-1:0]        rf_ra2_o,
  input  logic [DATA_W-1:0]        rf_rd1_i,
  input  logic [DATA_W-1:0]        rf_rd2_i,
  input  logic [FWD_N-1:0]         fwd_wreg_i,
  input  logic [FWD_N*REG_AW-1:0]  fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0]  fwd_wdata_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              pc_o,
  output logic [7:0]               aluop_o,
  output logic [2:0]               alusel_o,
  output logic [DATA_W-1:0]        reg1_o,
  output logic [DATA_W-1:0]        reg2_o,
  output logic [REG_AW-1:0]        wd_o,
  output logic                     wreg_o,
  output logic                     is_load_o,
  output logic                     inst_err_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                         F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;

  localparam logic [7:0] ALU_NOP = 8'h00, ALU_AND = 8'h24, ALU_OR = 8'h25,
                         ALU_XOR = 8'h26, ALU_NOR = 8'h27, ALU_SLL = 8'h7C,
                         ALU_SRL = 8'h02, ALU_SRA = 8'h03, ALU_LW = 8'hE3;
  localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_LOAD = 3'd7;

  logic [5:0]        op, funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_zext, imm_sext, imm_lui, sa_zext;

  assign op       = inst_i[31:26];
  assign funct    = inst_i[5:0];
  assign imm      = inst_i[15:0];
  assign imm_zext = DATA_W'(imm);
  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_lui  = DATA_W'({imm, 16'h0000});
  assign sa_zext  = DATA_W'(inst_i[10:6]);

  assign rf_ra1_o = REG_AW'(inst_i[25:21]);
  assign rf_ra2_o = REG_AW'(inst_i[20:16]);

  logic [7:0]        d_aluop;
  logic [2:0]        d_alusel;
  logic [DATA_W-1:0] d_imm1, d_imm2;
  logic [REG_AW-1:0] d_wd;
  logic              d_wreg, d_load, d_err;

  always_comb begin
    d_aluop  = ALU_NOP;
    d_alusel = SEL_NOP;
    rf_re1_o = 1'b0;
    rf_re2_o = 1'b0;
    d_imm1   = '0;
    d_imm2   = '0;
    d_wd     = '0;
    d_wreg   = 1'b0;
    d_load   = 1'b0;
    d_err    = 1'b0;
    case (op)
      OP_ORI, OP_ANDI, OP_XORI: begin
        d_aluop  = (op == OP_ORI) ? ALU_OR : (op == OP_ANDI) ? ALU_AND : ALU_XOR;
        d_alusel = SEL_LOGIC;
        rf_re1_o = 1'b1;
        d_imm2   = imm_zext;
        d_wd     = rf_ra2_o;
        d_wreg   = 1'b1;
      end
      OP_LUI: begin
        // rs is not read, so operand 1 falls back to the zero in d_imm1.
        d_aluop  = ALU_OR;
        d_alusel = SEL_LOGIC;
        d_imm2   = imm_lui;
        d_wd     = rf_ra2_o;
        d_wreg   = 1'b1;
      end
      OP_LW: begin
        d_aluop  = ALU_LW;
        d_alusel = SEL_LOAD;
        rf_re1_o = 1'b1;
        d_imm2   = imm_sext;
        d_wd     = rf_ra2_o;
        d_wreg   = 1'b1;
        d_load   = 1'b1;
      end
      OP_SPECIAL: begin
        // An all-zero word is the canonical NOP, not SLL $0,$0,0.
        if (inst_i != 32'h0) begin
          case (funct)
            F_OR, F_AND, F_XOR, F_NOR: begin
              d_aluop  = (funct == F_OR) ? ALU_OR : (funct == F_AND) ? ALU_AND :
                         (funct == F_XOR) ? ALU_XOR : ALU_NOR;
              d_alusel = SEL_LOGIC;
              rf_re1_o = 1'b1;
              rf_re2_o = 1'b1;
              d_wd     = REG_AW'(inst_i[15:11]);
              d_wreg   = 1'b1;
            end
            F_SLL, F_SRL, F_SRA: begin
              d_aluop  = (funct == F_SLL) ? ALU_SLL : (funct == F_SRL) ? ALU_SRL : ALU_SRA;
              d_alusel = SEL_SHIFT;
              rf_re2_o = 1'b1;
              d_imm1   = sa_zext;
              d_wd     = REG_AW'(inst_i[15:11]);
              d_wreg   = 1'b1;
            end
            default: d_err = 1'b1;
          endcase
        end
      end
      default: d_err = 1'b1;
    endcase
  end

  // Operand resolution. Scanning from the oldest source down lets the
  // youngest matching source overwrite older ones.
  logic [DATA_W-1:0] opnd1, opnd2;

  always_comb begin
    opnd1 = rf_rd1_i;
    opnd2 = rf_rd2_i;
    for (int i = FWD_N - 1; i >= 0; i--) begin
      if (fwd_wreg_i[i] && (fwd_wd_i[i*REG_AW +: REG_AW] == rf_ra1_o))
        opnd1 = fwd_wdata_i[i*DATA_W +: DATA_W];
      if (fwd_wreg_i[i] && (fwd_wd_i[i*REG_AW +: REG_AW] == rf_ra2_o))
        opnd2 = fwd_wdata_i[i*DATA_W +: DATA_W];
    end
    if (rf_ra1_o == '0) opnd1 = '0;
    if (rf_ra2_o == '0) opnd2 = '0;
    if (!rf_re1_o) opnd1 = d_imm1;
    if (!rf_re2_o) opnd2 = d_imm2;
  end

  logic load_use, advance;

  // The held load's data is not available yet, so a dependent instruction
  // waits one cycle and picks the data up from a later forwarding source.
  assign load_use = in_valid & out_valid & is_load_o & wreg_o &
                    ((rf_re1_o & (rf_ra1_o == wd_o)) | (rf_re2_o & (rf_ra2_o == wd_o)));
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance & ~load_use & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      pc_o        <= '0;
      aluop_o     <= '0;
      alusel_o    <= '0;
      reg1_o      <= '0;
      reg2_o      <= '0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      is_load_o   <= 1'b0;
      inst_err_o  <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance && load_use) begin
        out_valid <= 1'b0;
        wreg_o    <= 1'b0;
        is_load_o <= 1'b0;
      end else if (advance && in_valid) begin
        out_valid  <= 1'b1;
        pc_o       <= pc_i;
        aluop_o    <= d_aluop;
        alusel_o   <= d_alusel;
        reg1_o     <= opnd1;
        reg2_o     <= opnd2;
        wd_o       <= d_wd;
        wreg_o     <= d_wreg & (d_wd != '0);
        is_load_o  <= d_load;
        inst_err_o <= d_err;
      end else if (advance) begin
        out_valid <= 1'b0;
      end

      if (load_use && advance && !flush && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
module tb_id_stage_fwd;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int FWD_N  = 3;
  // Narrow counter so saturation is reachable in a short run.
  localparam int CNT_W  = 10;

  localparam logic [7:0] A_NOP = 8'h00, A_AND = 8'h24, A_OR = 8'h25, A_XOR = 8'h26,
                         A_NOR = 8'h27, A_SLL = 8'h7C, A_SRL = 8'h02, A_SRA = 8'h03,
                         A_LW = 8'hE3;
  localparam logic [2:0] S_NOP = 3'd0, S_LOGIC = 3'd1, S_SHIFT = 3'd2, S_LOAD = 3'd7;

  logic clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] pc, inst, rf_rd1, rf_rd2;
  logic rf_re1, rf_re2;
  logic [REG_AW-1:0] rf_ra1, rf_ra2, wd_o;
  logic [FWD_N-1:0] fwd_wreg;
  logic [FWD_N*REG_AW-1:0] fwd_wd;
  logic [FWD_N*DATA_W-1:0] fwd_wdata;
  logic [31:0] pc_o, reg1_o, reg2_o;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic wreg_o, is_load_o, inst_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  logic        fw_en [FWD_N];
  logic [4:0]  fw_wd [FWD_N];
  logic [31:0] fw_dat[FWD_N];

  int n_checks = 0;
  int n_pass = 0;

  id_stage_fwd #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc), .inst_i(inst), .rf_re1_o(rf_re1), .rf_re2_o(rf_re2),
    .rf_ra1_o(rf_ra1), .rf_ra2_o(rf_ra2), .rf_rd1_i(rf_rd1), .rf_rd2_i(rf_rd2),
    .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o), .aluop_o(aluop_o),
    .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
    .wreg_o(wreg_o), .is_load_o(is_load_o), .inst_err_o(inst_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    fwd_wreg  = '0;
    fwd_wd    = '0;
    fwd_wdata = '0;
    for (int i = 0; i < FWD_N; i++) begin
      fwd_wreg[i]               = fw_en[i];
      fwd_wd[i*REG_AW +: REG_AW] = fw_wd[i];
      fwd_wdata[i*DATA_W +: DATA_W] = fw_dat[i];
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic re1, re2;
    logic [7:0] aluop; logic [2:0] alusel;
    logic [31:0] r1, r2;
    logic [4:0] wd; logic wreg, ld, err;
  } dec_t;

  typedef struct packed {
    logic vld; logic [31:0] pc; logic [7:0] aluop; logic [2:0] alusel;
    logic [31:0] r1, r2; logic [4:0] wd; logic wreg, ld, err;
    logic [CNT_W-1:0] cnt;
  } st_t;

  st_t m;

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < FWD_N; i++)
      if (fw_en[i] && fw_wd[i] == a) return fw_dat[i];
    return rf;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t d;
    logic [31:0] i1, i2;
    d = '0; i1 = '0; i2 = '0;
    case (w[31:26])
      6'h0D, 6'h0C, 6'h0E: begin
        d.aluop = (w[31:26] == 6'h0D) ? A_OR : (w[31:26] == 6'h0C) ? A_AND : A_XOR;
        d.alusel = S_LOGIC; d.re1 = 1'b1; i2 = {16'h0, w[15:0]};
        d.wd = w[20:16]; d.wreg = 1'b1;
      end
      6'h0F: begin
        d.aluop = A_OR; d.alusel = S_LOGIC; i2 = {w[15:0], 16'h0};
        d.wd = w[20:16]; d.wreg = 1'b1;
      end
      6'h23: begin
        d.aluop = A_LW; d.alusel = S_LOAD; d.re1 = 1'b1;
        i2 = {{16{w[15]}}, w[15:0]}; d.wd = w[20:16]; d.wreg = 1'b1; d.ld = 1'b1;
      end
      6'h00: begin
        if (w != 32'h0) begin
          case (w[5:0])
            6'h25: begin d.aluop = A_OR;  d.alusel = S_LOGIC; d.re1 = 1; d.re2 = 1; d.wd = w[15:11]; d.wreg = 1; end
            6'h24: begin d.aluop = A_AND; d.alusel = S_LOGIC; d.re1 = 1; d.re2 = 1; d.wd = w[15:11]; d.wreg = 1; end
            6'h26: begin d.aluop = A_XOR; d.alusel = S_LOGIC; d.re1 = 1; d.re2 = 1; d.wd = w[15:11]; d.wreg = 1; end
            6'h27: begin d.aluop = A_NOR; d.alusel = S_LOGIC; d.re1 = 1; d.re2 = 1; d.wd = w[15:11]; d.wreg = 1; end
            6'h00: begin d.aluop = A_SLL; d.alusel = S_SHIFT; d.re2 = 1; i1 = {27'h0, w[10:6]}; d.wd = w[15:11]; d.wreg = 1; end
            6'h02: begin d.aluop = A_SRL; d.alusel = S_SHIFT; d.re2 = 1; i1 = {27'h0, w[10:6]}; d.wd = w[15:11]; d.wreg = 1; end
            6'h03: begin d.aluop = A_SRA; d.alusel = S_SHIFT; d.re2 = 1; i1 = {27'h0, w[10:6]}; d.wd = w[15:11]; d.wreg = 1; end
            default: d.err = 1'b1;
          endcase
        end
      end
      default: d.err = 1'b1;
    endcase
    d.r1 = d.re1 ? ref_operand(w[25:21], rf_rd1) : i1;
    d.r2 = d.re2 ? ref_operand(w[20:16], rf_rd2) : i2;
    if (d.wd == 5'd0) d.wreg = 1'b0;
    return d;
  endfunction

  function automatic logic ref_load_use();
    dec_t d;
    d = ref_decode(inst);
    return in_valid && m.vld && m.ld && m.wreg &&
           ((d.re1 && inst[25:21] == m.wd) || (d.re2 && inst[20:16] == m.wd));
  endfunction

  function automatic logic ref_in_ready();
    return (out_ready || !m.vld) && !ref_load_use() && !flush;
  endfunction

  function automatic st_t dut_state();
    return {out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
            wreg_o, is_load_o, inst_err_o, stall_cnt_o};
  endfunction

  // Advance the model by the same edge the DUT sees.
  task automatic tick();
    dec_t d; logic lu, adv; st_t n;
    d = ref_decode(inst);
    lu = ref_load_use();
    adv = out_ready || !m.vld;
    n = m;
    if (flush) n.vld = 1'b0;
    else if (adv && lu) begin n.vld = 1'b0; n.wreg = 1'b0; n.ld = 1'b0; end
    else if (adv && in_valid) begin
      n.vld = 1'b1; n.pc = pc; n.aluop = d.aluop; n.alusel = d.alusel;
      n.r1 = d.r1; n.r2 = d.r2; n.wd = d.wd; n.wreg = d.wreg; n.ld = d.ld; n.err = d.err;
    end else if (adv) n.vld = 1'b0;
    if (lu && adv && !flush && m.cnt != {CNT_W{1'b1}}) n.cnt = m.cnt + 1'b1;
    @(posedge clk); #1;
    m = n;
  endtask

  task automatic set_idle();
    flush = 0; in_valid = 0; out_ready = 1; pc = 0; inst = 0; rf_rd1 = 0; rf_rd2 = 0;
    for (int i = 0; i < FWD_N; i++) begin fw_en[i] = 0; fw_wd[i] = 0; fw_dat[i] = 0; end
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    m = '0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd, sa; logic [15:0] imm;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sa = 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 13))
      0:  return {6'h0D, rs, rt, imm};
      1:  return {6'h0C, rs, rt, imm};
      2:  return {6'h0E, rs, rt, imm};
      3:  return {6'h0F, rs, rt, imm};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      5:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      6:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      7:  return {6'h00, rs, rt, rd, 5'd0, 6'h27};
      8:  return {6'h00, 5'd0, rt, rd, sa, 6'h00};
      9:  return {6'h00, 5'd0, rt, rd, sa, 6'h02};
      10: return {6'h00, 5'd0, rt, rd, sa, 6'h03};
      11: return {6'h23, rs, rt, imm};
      12: return 32'h0;
      default: return ($urandom_range(0, 1) == 0) ? {6'h3F, rs, rt, imm}
                                                   : {6'h00, rs, rt, rd, sa, 6'h3F};
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 0;
    inst = 32'h34220005; in_valid = 1; pc = 32'h44; rf_rd1 = 32'h99;
    @(posedge clk); #1;
    rst = 1; flush = 1;
    @(posedge clk); #1;
    rst = 0; flush = 0; in_valid = 0;
    m = '0;
    #1;
    n_checks++;
    if (dut_state() !== st_t'('0)) $display("FAIL reset_state got=%h want=0", dut_state());
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_ori();
    do_reset();
    inst = 32'h34220005; pc = 32'h100; rf_rd1 = 32'h10; in_valid = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ori_in_ready got=%b want=1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, reg1_o, reg2_o, wd_o, wreg_o} !== {1'b1, 32'h10, 32'h5, 5'd2, 1'b1})
      $display("FAIL ori_fields got v=%b r1=%h r2=%h wd=%0d wreg=%b want v=1 r1=10 r2=5 wd=2 wreg=1",
               out_valid, reg1_o, reg2_o, wd_o, wreg_o);
    else n_pass++;
    n_checks++;
    if (dut_state() !== m) $display("FAIL ori_model got=%h want=%h", dut_state(), m); else n_pass++;
  endtask

  task automatic test_fwd_priority();
    do_reset();
    inst = 32'h34670001; rf_rd1 = 32'h1234; in_valid = 1;
    fw_en[0] = 1; fw_wd[0] = 5'd3; fw_dat[0] = 32'hAAAA;
    fw_en[1] = 1; fw_wd[1] = 5'd3; fw_dat[1] = 32'hBBBB;
    tick();
    n_checks++;
    if (reg1_o !== 32'hAAAA) $display("FAIL fwd_youngest got=%h want=0000aaaa", reg1_o); else n_pass++;
    fw_en[0] = 0;
    tick();
    n_checks++;
    if (reg1_o !== 32'hBBBB) $display("FAIL fwd_older got=%h want=0000bbbb", reg1_o); else n_pass++;
    inst = 32'h34070001; fw_en[0] = 1; fw_wd[0] = 5'd0; fw_wd[1] = 5'd0;
    tick();
    n_checks++;
    if ({reg1_o, reg2_o} !== {32'h0, 32'h1}) $display("FAIL fwd_reg0 got r1=%h r2=%h want r1=0 r2=1", reg1_o, reg2_o);
    else n_pass++;
    in_valid = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    inst = 32'h8C240000; rf_rd1 = 32'h40; in_valid = 1;
    tick();
    inst = 32'h00862825; rf_rd2 = 32'h6;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL lu_stall_in_ready got=%b want=0", in_ready); else n_pass++;
    tick();
    n_checks++;
    if ({out_valid, wreg_o, stall_cnt_o} !== {1'b0, 1'b0, CNT_W'(1)})
      $display("FAIL lu_bubble got v=%b wreg=%b cnt=%0d want v=0 wreg=0 cnt=1", out_valid, wreg_o, stall_cnt_o);
    else n_pass++;
    fw_en[1] = 1; fw_wd[1] = 5'd4; fw_dat[1] = 32'hDEAD;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL lu_accept_in_ready got=%b want=1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, aluop_o, wd_o, reg1_o, reg2_o, stall_cnt_o} !== {1'b1, A_OR, 5'd5, 32'hDEAD, 32'h6, CNT_W'(1)})
      $display("FAIL lu_dependent got v=%b op=%h wd=%0d r1=%h r2=%h cnt=%0d want v=1 op=25 wd=5 r1=dead r2=6 cnt=1",
               out_valid, aluop_o, wd_o, reg1_o, reg2_o, stall_cnt_o);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    st_t snap;
    do_reset();
    inst = 32'h34220005; pc = 32'h200; in_valid = 1;
    tick();
    snap = dut_state();
    out_ready = 0; inst = 32'h34220007; pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, in_ready); else n_pass++;
      tick();
      n_checks++;
      if (dut_state() !== snap) $display("FAIL bp_hold cyc=%0d got=%h want=%h", k, dut_state(), snap); else n_pass++;
    end
    out_ready = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got=%b want=1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, pc_o, reg2_o} !== {1'b1, 32'h204, 32'h7})
      $display("FAIL bp_next got v=%b pc=%h r2=%h want v=1 pc=204 r2=7", out_valid, pc_o, reg2_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    inst = 32'h34220005; pc = 32'h300; in_valid = 1;
    tick();
    inst = 32'h34220009; pc = 32'h304; flush = 1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b want=0", in_ready); else n_pass++;
    tick();
    flush = 0; in_valid = 0;
    n_checks++;
    if ({out_valid, pc_o} !== {1'b0, 32'h300})
      $display("FAIL flush_drop got v=%b pc=%h want v=0 pc=300", out_valid, pc_o);
    else n_pass++;
    // Load followed by a dependent under flush: no stall counted.
    do_reset();
    inst = 32'h8C240000; in_valid = 1;
    tick();
    inst = 32'h00862825; flush = 1;
    tick();
    flush = 0; in_valid = 0;
    n_checks++;
    if ({out_valid, stall_cnt_o} !== {1'b0, CNT_W'(0)})
      $display("FAIL flush_lu got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt_o);
    else n_pass++;
  endtask

  task automatic test_bad_opcode();
    do_reset();
    inst = 32'hFC000000; in_valid = 1;
    tick();
    n_checks++;
    if ({out_valid, inst_err_o, wreg_o} !== 3'b110)
      $display("FAIL bad_opcode got v=%b err=%b wreg=%b want v=1 err=1 wreg=0", out_valid, inst_err_o, wreg_o);
    else n_pass++;
    inst = 32'h0;
    tick();
    in_valid = 0;
    n_checks++;
    if ({out_valid, inst_err_o, wreg_o, aluop_o} !== {3'b100, A_NOP})
      $display("FAIL nop got v=%b err=%b wreg=%b op=%h want v=1 err=0 wreg=0 op=00",
               out_valid, inst_err_o, wreg_o, aluop_o);
    else n_pass++;
  endtask

  task automatic test_random();
    dec_t d;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      inst = rand_inst(); pc = $urandom;
      rf_rd1 = $urandom; rf_rd2 = $urandom;
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < FWD_N; i++) begin
        fw_en[i] = ($urandom_range(0, 1) == 1);
        fw_wd[i] = 5'($urandom_range(0, 7));
        fw_dat[i] = $urandom;
      end
      #1;
      d = ref_decode(inst);
      n_checks++;
      if ({in_ready, rf_re1, rf_re2, rf_ra1, rf_ra2} !== {ref_in_ready(), d.re1, d.re2, inst[25:21], inst[20:16]})
        $display("FAIL rnd_comb cyc=%0d got rdy=%b re=%b%b ra=%0d,%0d want rdy=%b re=%b%b ra=%0d,%0d", k,
                 in_ready, rf_re1, rf_re2, rf_ra1, rf_ra2, ref_in_ready(), d.re1, d.re2, inst[25:21], inst[20:16]);
      else n_pass++;
      tick();
      n_checks++;
      if (dut_state() !== m) $display("FAIL rnd_state cyc=%0d got=%h want=%h", k, dut_state(), m);
      else n_pass++;
    end
    set_idle();
  endtask

  task automatic test_saturation();
    do_reset();
    inst = 32'h8C840000; in_valid = 1; out_ready = 1;
    for (int k = 0; k < 2 * (1 << CNT_W) + 8; k++) tick();
    in_valid = 0;
    n_checks++;
    if (stall_cnt_o !== {CNT_W{1'b1}}) $display("FAIL stall_sat got=%h want=%h", stall_cnt_o, {CNT_W{1'b1}});
    else n_pass++;
    n_checks++;
    if (dut_state() !== m) $display("FAIL stall_sat_model got=%h want=%h", dut_state(), m); else n_pass++;
  endtask

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_ori();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_bad_opcode();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
